// File: rtl/ap_pkg.sv
// Shared definitions for the associative processor datapath:
// default geometry, CAM mode encodings and the address-width helper.
package ap_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int CELL_QUANT_DEF = 512;

  typedef enum logic {
    CAM_MODE_RAM = 1'b0,
    CAM_MODE_AP  = 1'b1
  } cam_mode_e;

  // Bits needed to hold the value itself (512 -> 10).
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/cam_cell.sv
// One CAM row: two words (internal columns 0/1) with RAM write,
// masked AP write and a masked match against the selected column.
module cam_cell
  import ap_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic                 ram_we_i,
  input  logic                 ap_we_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [WORD_SIZE-1:0] key_i,
  input  logic [WORD_SIZE-1:0] mask_i,
  output logic [WORD_SIZE-1:0] word_o,
  output logic                 match_o
);

  logic [1:0][WORD_SIZE-1:0] word_q;
  logic [1:0][WORD_SIZE-1:0] word_d;
  logic [WORD_SIZE-1:0]      ap_word;

  // Unmasked bits keep their stored value.
  assign ap_word = (word_q[sel_i] & ~mask_i)
                 | (data_i & mask_i);

  always_comb begin
    word_d = word_q;
    if (ram_we_i) begin
      word_d[sel_i] = data_i;
    end else if (ap_we_i) begin
      word_d[sel_i] = ap_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o  = word_q[sel_i];
  assign match_o = ((word_o ^ key_i) & mask_i) == '0;

endmodule

// File: rtl/cam_array.sv
// CAM column of CELL_QUANT two-word rows with RAM and AP access.
// CAM_TAG_REG_EN registers the tag vector (reset to 0).
module cam_array
  import ap_pkg::*;
#(
  parameter  int WORD_SIZE  = WORD_SIZE_DEF,
  parameter  int CELL_QUANT = CELL_QUANT_DEF,
  localparam int ADDR_W     = clogb2(CELL_QUANT)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
  input  logic                  sel_internal_col,
  input  logic                  cam_mode,
  input  logic [WORD_SIZE-1:0]  data_in,
  input  logic [WORD_SIZE-1:0]  key,
  input  logic [WORD_SIZE-1:0]  mask,
  input  logic                  wea,
  output logic [CELL_QUANT-1:0] tags,
  output logic [WORD_SIZE-1:0]  data_out
);

  localparam int IDX_W =
    (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;

  logic                  ram_mode;
  logic                  ap_mode;
  logic                  addr_ok;
  logic [CELL_QUANT-1:0] match_w;
  logic [WORD_SIZE-1:0]  rd_w [CELL_QUANT];
  logic [WORD_SIZE-1:0]  data_out_q;
  logic [WORD_SIZE-1:0]  data_out_d;

  assign ram_mode = cam_mode == logic'(CAM_MODE_RAM);
  assign ap_mode  = cam_mode == logic'(CAM_MODE_AP);
  assign addr_ok  = addr_in < ADDR_W'(CELL_QUANT);

  for (genvar r = 0; r < CELL_QUANT; r++) begin : g_row
    logic ram_we;
    logic ap_we;

    assign ram_we = ram_mode && wea
                 && addr_in == ADDR_W'(r);
    assign ap_we  = ap_mode && cell_wea_ctrl_ap[r];

    cam_cell #(
      .WORD_SIZE(WORD_SIZE)
    ) u_cell (
      .clk_i   (CLK100MHZ),
      .rst_ni  (rst),
      .sel_i   (sel_internal_col),
      .ram_we_i(ram_we),
      .ap_we_i (ap_we),
      .data_i  (data_in),
      .key_i   (key),
      .mask_i  (mask),
      .word_o  (rd_w[r]),
      .match_o (match_w[r])
    );
  end

  // Read-first: the mux sees pre-edge contents.
  always_comb begin
    data_out_d = '0;
    if (addr_ok) begin
      data_out_d = rd_w[addr_in[IDX_W-1:0]];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef CAM_TAG_REG_EN
  logic [CELL_QUANT-1:0] tags_q;

  always_ff @(posedge CLK100MHZ) begin
    if (!rst) begin
      tags_q <= '0;
    end else begin
      tags_q <= match_w;
    end
  end

  assign tags = tags_q;
`else
  assign tags = match_w;
`endif

endmodule

// File: tb/tb_cam_array.sv
// Randomized scoreboard bench for cam_array against an
// array-based reference model of the two-column CAM.
module tb_cam_array;

  localparam int W  = 8;
  localparam int N  = 512;
  localparam int AW = 10;

  typedef struct {
    logic [N-1:0] tags;
    logic [W-1:0] dout;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr_in;
  logic [N-1:0]  cell_wea_ctrl_ap;
  logic          sel_internal_col;
  logic          cam_mode;
  logic [W-1:0]  data_in;
  logic [W-1:0]  key;
  logic [W-1:0]  mask;
  logic          wea;
  logic [N-1:0]  tags;
  logic [W-1:0]  data_out;

  int compared;
  int mismatched;
  exp_t exp_q[$];
  logic [W-1:0] mem [2][N];

  cam_array dut (
    .CLK100MHZ       (clk),
    .rst             (rst),
    .addr_in         (addr_in),
    .cell_wea_ctrl_ap(cell_wea_ctrl_ap),
    .sel_internal_col(sel_internal_col),
    .cam_mode        (cam_mode),
    .data_in         (data_in),
    .key             (key),
    .mask            (mask),
    .wea             (wea),
    .tags            (tags),
    .data_out        (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; the model yields pre-edge tags and post-edge read.
  task automatic step(
    input logic          r,
    input logic          m,
    input logic          s,
    input logic [AW-1:0] a,
    input logic          w,
    input logic [W-1:0]  d,
    input logic [W-1:0]  k,
    input logic [W-1:0]  mk,
    input logic [N-1:0]  ap
  );
    exp_t e;
    @(negedge clk);
    rst = r;
    cam_mode = m;
    sel_internal_col = s;
    addr_in = a;
    wea = w;
    data_in = d;
    key = k;
    mask = mk;
    cell_wea_ctrl_ap = ap;
    for (int i = 0; i < N; i++) begin
      e.tags[i] = ((mem[s][i] ^ k) & mk) == 0;
    end
    if (!r || int'(a) >= N) e.dout = '0;
    else e.dout = mem[s][a];
    if (!r) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < N; i++) mem[c][i] = '0;
    end else if (m == 1'b0) begin
      if (w && int'(a) < N) mem[s][a] = d;
    end else begin
      for (int i = 0; i < N; i++)
        if (ap[i]) mem[s][i] = (mem[s][i] & ~mk) | (d & mk);
    end
    exp_q.push_back(e);
  endtask

  task automatic ram_wr(input logic s, input int a,
                        input logic [W-1:0] d);
    step(1, 0, s, AW'(a), 1, d, 8'h00, 8'hFF, '0);
  endtask

  task automatic rd(input logic s, input int a);
    step(1, 0, s, AW'(a), 0, 8'h00, 8'h00, 8'hFF, '0);
  endtask

  // Monitor: tags just before the edge, data_out just after.
  initial begin
    exp_t e;
    logic [N-1:0] t;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tags;
        @(posedge clk);
        #1;
        compared++;
        if (t !== e.tags) begin
          mismatched++;
          $display("FAIL tags got=%h exp=%h", t, e.tags);
        end
        compared++;
        if (data_out !== e.dout) begin
          mismatched++;
          $display("FAIL data_out got=%h exp=%h",
                   data_out, e.dout);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ap;
    logic [N-1:0] none;
    int a;
    compared = 0;
    mismatched = 0;
    none = '0;
    rst = 1'b0;
    cam_mode = 1'b0;
    sel_internal_col = 1'b0;
    addr_in = '0;
    wea = 1'b0;
    data_in = '0;
    key = '0;
    mask = '0;
    cell_wea_ctrl_ap = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < N; i++) mem[c][i] = '0;
    repeat (2) @(posedge clk);

    // Reset state, then read after reset.
    step(0, 0, 0, AW'(3), 0, 8'h00, 8'h00, 8'hFF, none);
    rd(0, 3);
    rd(1, 100);

    // RAM write/read and column isolation.
    ram_wr(0, 3, 8'hA5);
    ram_wr(0, 7, 8'h3C);
    rd(0, 3);
    rd(0, 7);
    rd(1, 3);

    // Masked compare.
    ram_wr(0, 0, 8'h81);
    ram_wr(0, 1, 8'h01);
    ram_wr(0, 2, 8'h80);
    step(1, 0, 0, AW'(0), 0, 8'h00, 8'h01, 8'h01, none);
    step(1, 0, 0, AW'(0), 0, 8'h00, 8'h81, 8'h81, none);
    step(1, 0, 0, AW'(0), 0, 8'h00, 8'h5A, 8'h00, none);

    // AP parallel write with a stray wea at row 2.
    ram_wr(0, 0, 8'hF0);
    ram_wr(0, 1, 8'hF0);
    ap = none;
    ap[0] = 1'b1;
    ap[1] = 1'b1;
    step(1, 1, 0, AW'(2), 1, 8'h05, 8'hF5, 8'h0F, ap);
    rd(0, 0);
    rd(0, 1);
    rd(0, 2);
    step(1, 1, 0, AW'(2), 1, 8'hFF, 8'h00, 8'hFF, none);
    rd(0, 2);

    // Read-during-write at address 5.
    ram_wr(0, 5, 8'h11);
    ram_wr(0, 5, 8'h22);
    rd(0, 5);

    // Out-of-range address: write dropped, read gives 0.
    ram_wr(1, 700, 8'h77);
    rd(1, 700);

    // Reset with an AP write pending.
    step(1, 1, 0, AW'(0), 0, 8'hFF, 8'hFF, 8'hFF, ~none);
    step(0, 1, 0, AW'(0), 0, 8'h3C, 8'h00, 8'hFF, ~none);
    rd(0, 0);
    step(1, 0, 0, AW'(0), 0, 8'h00, 8'h00, 8'hFF, none);

    // Randomized mix over a small hot row range for frequent matches.
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < N / 32; j++)
        ap[j*32 +: 32] = $urandom & $urandom;
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023)
                                     : $urandom_range(0, 15);
      step(($urandom_range(0, 60) != 0),
           1'($urandom), 1'($urandom), AW'(a), 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), ap);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
